// File: rtl/mem_arb.sv
// N-channel arbiter sharing one memory port; fixed or round-robin grant, registered memory
// interface, configurable read latency and a one-cycle per-channel ack pulse.
module mem_arb #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_RD_LAT = 1,
    parameter int unsigned PRIO_MODE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_ce_i,
    input  logic [NUM_CH-1:0]        ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*4-1:0]      ch_width_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic                     mem_ce_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [3:0]               mem_width_o,
    output logic [DATA_W-1:0]        mem_data_o,
    input  logic [DATA_W-1:0]        mem_data_i
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_width_q, mem_width_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic                sel_valid;
    logic [IdxW-1:0]     sel_idx;

    // Scan from the lowest priority to the highest so the last hit is the winner.
    always_comb begin
        sel_valid = |ch_ce_i;
        sel_idx   = '0;
        if (PRIO_MODE == 0) begin
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (ch_ce_i[i]) sel_idx = IdxW'(i);
            end
        end else begin
            for (int i = int'(NUM_CH); i >= 1; i--) begin
                if (ch_ce_i[(int'(last_q) + i) % int'(NUM_CH)]) begin
                    sel_idx = IdxW'((int'(last_q) + i) % int'(NUM_CH));
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
        mem_data_d  = mem_data_q;
        ack_d       = '0;
        rdata_d     = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    grant_d     = sel_idx;
                    last_d      = sel_idx;
                    cnt_d       = CntW'(MEM_RD_LAT);
                    mem_ce_d    = 1'b1;
                    mem_we_d    = ch_we_i[sel_idx];
                    mem_addr_d  = ch_addr_i[sel_idx*ADDR_W +: ADDR_W];
                    mem_width_d = ch_width_i[sel_idx*4 +: 4];
                    mem_data_d  = ch_data_i[sel_idx*DATA_W +: DATA_W];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (mem_we_q || (MEM_RD_LAT == 0)) begin
                    if (!mem_we_q) rdata_d = mem_data_i;
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack_d    = NUM_CH'(1) << grant_q;
                    state_d  = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    rdata_d  = mem_data_i;
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack_d    = NUM_CH'(1) << grant_q;
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= IdxW'(NUM_CH - 1);
            cnt_q       <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= '0;
            mem_data_q  <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_data_q  <= mem_data_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ch_ack_o    = ack_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_width_o = mem_width_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: three instances (round robin lat 1, fixed priority lat 3, round robin
// lat 0), each with a small sram model that only drives valid data in the capture cycle.
module tb_mem_arb;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n [3];
    logic [NCH-1:0]    ce    [3];
    logic [NCH-1:0]    we    [3];
    logic [NCH*AW-1:0] addr  [3];
    logic [NCH*4-1:0]  wid   [3];
    logic [NCH*DW-1:0] wdat  [3];
    logic [NCH-1:0]    ack   [3];
    logic [DW-1:0]     rdata [3];
    logic              busy  [3];
    logic              mce   [3];
    logic              mwe   [3];
    logic [AW-1:0]     maddr [3];
    logic [3:0]        mwid  [3];
    logic [DW-1:0]     mdat  [3];
    logic [DW-1:0]     mrd   [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int Lat  = (g == 1) ? 3 : ((g == 2) ? 0 : 1);
        localparam int Prio = (g == 1) ? 0 : 1;
        logic [31:0] sram [64];
        int          run = 0;

        mem_arb #(
            .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(Lat), .PRIO_MODE(Prio)
        ) u_dut (
            .clk(clk), .rst(rst_n[g]),
            .ch_ce_i(ce[g]), .ch_we_i(we[g]), .ch_addr_i(addr[g]), .ch_width_i(wid[g]),
            .ch_data_i(wdat[g]), .ch_ack_o(ack[g]), .rdata_o(rdata[g]), .busy_o(busy[g]),
            .mem_ce_o(mce[g]), .mem_we_o(mwe[g]), .mem_addr_o(maddr[g]),
            .mem_width_o(mwid[g]), .mem_data_o(mdat[g]), .mem_data_i(mrd[g])
        );

        // Poison outside the one cycle where the read result is meant to be sampled.
        assign mrd[g] = (mce[g] && run == Lat) ? sram[maddr[g][7:2]] : 32'hbad0bad0;

        always @(posedge clk) begin
            if (mce[g] && mwe[g] && run == 0) sram[maddr[g][7:2]] <= mdat[g];
            run <= mce[g] ? run + 1 : 0;
        end
    end

    typedef struct {
        int          k;
        int          ch;
        logic [31:0] rd;
        int          at;
    } exp_t;

    typedef struct {
        int          ch;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  wd;
        logic [31:0] rd;
        int          dt;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pending(input int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].k == k) n++;
        return n;
    endfunction

    // One clock: score any acks, let acked channels drop ce, resume #1 after the edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (ack[k] != '0) begin
                int idx = -1;
                for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].k == k) idx = i;
                if (idx < 0) begin
                    check($sformatf("unexpected_ack_dut%0d", k), 64'(ack[k]), 64'd0);
                end else begin
                    check($sformatf("ack_ch_dut%0d", k), 64'(ack[k]), 64'(1 << sb[idx].ch));
                    check($sformatf("ack_cycle_dut%0d", k), 64'(cyc), 64'(sb[idx].at));
                    check($sformatf("rdata_dut%0d", k), 64'(rdata[k]), 64'(sb[idx].rd));
                    sb.delete(idx);
                end
                ce[k] = ce[k] & ~ack[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int ch, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] wd);
        ce[k][ch]             = 1'b1;
        we[k][ch]             = w;
        addr[k][ch*AW +: AW]  = a;
        wdat[k][ch*DW +: DW]  = d;
        wid[k][ch*4 +: 4]     = wd;
    endtask

    task automatic req(input int k, input int ch, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int dt);
        exp_t e;
        drive(k, ch, w, a, d, 4'(ch + 1));
        e.k  = k;
        e.ch = ch;
        e.rd = rd;
        e.at = cyc + dt;
        sb.push_back(e);
    endtask

    task automatic drain(input int k, input int budget);
        for (int n = 0; n < budget && (pending(k) != 0 || ce[k] != '0); n++) step();
        check($sformatf("drain_pending_dut%0d", k), 64'(pending(k)), 64'd0);
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_ack"}, 64'(ack[k]), 64'd0);
        check({tag, "_rdata"}, 64'(rdata[k]), 64'd0);
        check({tag, "_busy"}, 64'(busy[k]), 64'd0);
        check({tag, "_mem_ce"}, 64'(mce[k]), 64'd0);
        check({tag, "_mem_we"}, 64'(mwe[k]), 64'd0);
        check({tag, "_mem_addr"}, 64'(maddr[k]), 64'd0);
        check({tag, "_mem_data"}, 64'(mdat[k]), 64'd0);
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{2, 1'b1, 32'h10, 32'hdeadbeef, 4'h4, 32'h0,        2};
        tbl[1] = '{0, 1'b0, 32'h10, 32'h0,        4'h4, 32'hdeadbeef, 3};
        tbl[2] = '{1, 1'b1, 32'h20, 32'h12345678, 4'h2, 32'hdeadbeef, 2};
        tbl[3] = '{2, 1'b0, 32'h20, 32'h0,        4'h1, 32'h12345678, 3};
        tbl[4] = '{0, 1'b1, 32'h24, 32'ha5a5a5a5, 4'h4, 32'h12345678, 2};
        tbl[5] = '{1, 1'b0, 32'h24, 32'h0,        4'h4, 32'ha5a5a5a5, 3};
        tbl[6] = '{3, 1'b0, 32'h10, 32'h0,        4'h4, 32'hdeadbeef, 3};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            ce[k]    = '0;
            we[k]    = '0;
            addr[k]  = '0;
            wid[k]   = '0;
            wdat[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset_dut%0d", k));
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        step();

        // Single transactions on the round-robin, latency-1 instance.
        foreach (tbl[i]) begin
            req(0, tbl[i].ch, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].dt);
            wid[0][tbl[i].ch*4 +: 4] = tbl[i].wd;
            step();
            check($sformatf("vec%0d_mem_ce", i), 64'(mce[0]), 64'd1);
            check($sformatf("vec%0d_mem_we", i), 64'(mwe[0]), 64'(tbl[i].w));
            check($sformatf("vec%0d_mem_addr", i), 64'(maddr[0]), 64'(tbl[i].a));
            check($sformatf("vec%0d_mem_width", i), 64'(mwid[0]), 64'(tbl[i].wd));
            if (tbl[i].w) check($sformatf("vec%0d_mem_data", i), 64'(mdat[0]), 64'(tbl[i].d));
            drain(0, 20);
            step();
        end

        // Round-robin burst, then ch0+ch3 together: ch0 must win after ch3 was last.
        req(0, 0, 1'b0, 32'h20, 32'h0, 32'h12345678, 3);
        req(0, 1, 1'b0, 32'h24, 32'h0, 32'ha5a5a5a5, 7);
        req(0, 2, 1'b0, 32'h10, 32'h0, 32'hdeadbeef, 11);
        req(0, 3, 1'b0, 32'h20, 32'h0, 32'h12345678, 15);
        drain(0, 40);
        step();
        req(0, 0, 1'b0, 32'h24, 32'h0, 32'ha5a5a5a5, 3);
        req(0, 3, 1'b0, 32'h10, 32'h0, 32'hdeadbeef, 7);
        drain(0, 20);
        step();

        // Fixed priority on instance 1.
        req(1, 1, 1'b1, 32'h40, 32'h11112222, 32'h0, 2);
        req(1, 3, 1'b1, 32'h44, 32'h33334444, 32'h0, 5);
        drain(1, 20);
        step();
        req(1, 1, 1'b1, 32'h48, 32'h55556666, 32'h0, 2);
        drain(1, 20);
        step();
        req(1, 1, 1'b1, 32'h4c, 32'h77778888, 32'h0, 2);
        req(1, 3, 1'b1, 32'h50, 32'h9999aaaa, 32'h0, 5);
        drain(1, 20);
        step();
        req(1, 0, 1'b0, 32'h44, 32'h0, 32'h33334444, 5);
        drain(1, 20);
        step();

        // Asynchronous reset while a latency-3 read sits in WAIT; no ack may follow.
        drive(1, 1, 1'b0, 32'h40, 32'h0, 4'h4);
        repeat (3) step();
        check("midwait_mem_ce", 64'(mce[1]), 64'd1);
        check("midwait_busy", 64'(busy[1]), 64'd1);
        rst_n[1] = 1'b0;
        ce[1]    = '0;
        #1;
        check_zero(1, "async_reset");
        repeat (2) step();
        rst_n[1] = 1'b1;
        step();
        req(1, 1, 1'b0, 32'h40, 32'h0, 32'h11112222, 5);
        drain(1, 20);
        step();

        // Zero latency: write, then a read acked at T+2; a one-cycle ch2 pulse is ignored.
        req(2, 1, 1'b1, 32'h08, 32'hcafef00d, 32'h0, 2);
        drain(2, 20);
        step();
        req(2, 0, 1'b0, 32'h08, 32'h0, 32'hcafef00d, 2);
        step();
        check("zl_issue_mem_ce", 64'(mce[2]), 64'd1);
        drive(2, 2, 1'b0, 32'h0c, 32'h0, 4'h4);
        step();
        ce[2][2] = 1'b0;
        drain(2, 20);
        repeat (5) step();
        check("zl_idle_mem_ce", 64'(mce[2]), 64'd0);
        check("zl_idle_busy", 64'(busy[2]), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised N-channel arbiter that shares the single `mem`/`sram` port among several packet processors, the multi-`proc` successor to the one-processor, one-memory arrangement. Each channel issues one word/half/byte access at a time with a hold-until-ack request. The arbiter grants channels by fixed or round-robin priority, drives the memory port from registered outputs, waits a configurable read latency, and returns read data with a one-cycle ack pulse.

## Interface
- `NUM_CH`, default 4: number of requesting channels (2..8).
- `ADDR_W`, default 32: address width, matches `ADDR_BUS`.
- `DATA_W`, default 32: data width, matches `DATA_BUS`.
- `MEM_RD_LAT`, default 1: cycles from memory issue to valid `mem_data_i` (0..7).
- `PRIO_MODE`, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.

- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ch_ce_i` in NUM_CH: per-channel request; held high until that channel's ack.
- `ch_we_i` in NUM_CH: 1 = write, 0 = read.
- `ch_addr_i` in NUM_CH*ADDR_W: packed, channel i at `[i*ADDR_W +: ADDR_W]`.
- `ch_width_i` in NUM_CH*4: access width, passed through unchanged to `mem`.
- `ch_data_i` in NUM_CH*DATA_W: write data.
- `ch_ack_o` out NUM_CH: one-hot, one-cycle completion pulse.
- `rdata_o` out DATA_W: read data, valid in the ack cycle, held until the next read capture.
- `busy_o` out 1: high in every non-IDLE state.
- `mem_ce_o`, `mem_we_o` out 1: memory port controls.
- `mem_addr_o` out ADDR_W, `mem_width_o` out 4, `mem_data_o` out DATA_W: memory port fields.
- `mem_data_i` in DATA_W: memory read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `ch_ce_i` bit is high at the edge, latch grant `g`, then latch channel g's we, addr, width and data into the `mem_*` registers. Load `cnt = MEM_RD_LAT` and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `mem_ce_o = 1`, fields stable.
  - Write, or read with MEM_RD_LAT = 0: go to RESP. A zero-latency read captures `mem_data_i` into `rdata_o` at this edge.
  - Read with MEM_RD_LAT > 0: go to WAIT.
- **WAIT:** `mem_ce_o` and fields stay held. `cnt` decrements each cycle. At the edge where `cnt == 1`, capture `mem_data_i` into `rdata_o` and go to RESP.
- **RESP:** `mem_ce_o = 0`, `mem_we_o = 0`, `ch_ack_o[g] = 1`, then go to IDLE.
- Grant selection:
  - Fixed priority: lowest set index wins.
  - Round robin: search starts at `last + 1` mod NUM_CH. `last` updates to g when the grant is latched and resets to NUM_CH-1, so channel 0 has first priority after reset.
- Channel contract: the channel drops `ch_ce_i` in the cycle after it sees the ack, so it is low during the following IDLE cycle. A request still high in IDLE is treated as a new request.
- Request withdrawn before grant: no effect.
- Inputs changing after grant: ignored. The transaction completes with the latched fields and the ack is still issued.
- Writes never change `rdata_o`.
- Reset (asynchronous, any state): state goes to IDLE and `last` to NUM_CH-1. Every output and register goes to 0: `mem_*`, `ch_ack_o`, `rdata_o`, `busy_o`. An in-flight transaction is dropped with no ack.

## Timing
- Request first sampled high in IDLE cycle T:
  - `mem_ce_o` high in cycles T+1 .. T+1+MEM_RD_LAT for reads, and in T+1 only for writes.
  - Write ack in T+2.
  - Read ack and valid `rdata_o` in T+2+MEM_RD_LAT.
- Back-to-back service takes one IDLE cycle between transactions:
  - Read: 3 + MEM_RD_LAT cycles per transaction.
  - Write: 3 cycles per transaction.
- Throughput with all channels requesting under round robin: one transaction per channel every NUM_CH × transaction length. No channel waits more than NUM_CH−1 transactions.
- All outputs are registered. No combinational path runs from `ch_*` or `mem_data_i` to any output.

## Test plan
- **Write then read.** Setup: NUM_CH=4, MEM_RD_LAT=1, sram model attached. Stimulus: ch2 writes 0xdeadbeef to addr 0x10, width 4, with ce high in IDLE cycle T. Then ch0 reads 0x10.
  - Expected: `mem_we_o = 1` in T+1 and `ch_ack_o = 4'b0100` in T+2.
  - Expected for the read: `ch_ack_o = 4'b0001` with `rdata_o = 0xdeadbeef` 3 cycles after its IDLE sample.
- **Round-robin burst.** Stimulus: all 4 channels request reads at T, each dropping ce after its ack.
  - Expected: acks in order ch0, ch1, ch2, ch3 at T+3, T+7, T+11, T+15.
  - Expected: the next simultaneous ch0 + ch3 request is granted to ch0 first.
- **Fixed priority.** Setup: PRIO_MODE=0. Stimulus: ch1 and ch3 write at T.
  - Expected: ch1 ack at T+2, ch3 ack at T+5.
- **Reset mid-WAIT.** Setup: MEM_RD_LAT=3. Stimulus: pull `rst` low in WAIT.
  - Expected: all outputs 0 immediately, with no ack.
  - Expected after release: a ch1 read completes normally with its ack at T'+5.
- **Zero latency and withdrawal.** Setup: MEM_RD_LAT=0. Stimulus: a read is issued; separately, ch2 raises ce for one cycle while ch0 is in ISSUE.
  - Expected: the read acks at T+2 with data captured in ISSUE.
  - Expected: the withdrawn ch2 request produces no grant and no ack.
